memory_stage: RTL and testbench
===============================

# memory_stage

Memory-access stage directly downstream of the execute stage in the RISC-V core. It consumes the execute stage's 14-bit control word, ALU result, store data and calculated address. It performs byte, halfword and word loads and stores over a single-outstanding req/ready data-memory port, and produces a registered writeback bundle. It stalls the upstream pipeline while an access is outstanding and flags misaligned or illegal accesses instead of issuing them.

## Interface
- No parameters; all widths are fixed by the RV32 datapath.
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  execute-stage bundle valid this cycle
- in_ready  out  1  stage can accept a bundle; upstream holds its inputs while low
- control_word_ex  in  14  {branch_taken_ex, rf_wb, mem_we, wb_src[1:0], pc_src, rd[4:0], funct3[2:0]}
- ALU_result  in  32  execute result; already holds pc+4 for jumps and pc+imm for auipc
- calculated_adr  in  32  effective load/store byte address
- regfileb_ex  in  32  store data (rs2)
- dmem_req  out  1  memory request, held high until dmem_ready
- dmem_we  out  1  1 = store, 0 = load
- dmem_addr  out  32  word address, {addr[31:2], 2'b00}
- dmem_wstrb  out  4  byte-lane write enables; 0 for loads
- dmem_wdata  out  32  lane-replicated store data
- dmem_ready  in  1  access complete this cycle; dmem_rdata valid when !dmem_we
- dmem_rdata  in  32  load word
- out_valid  out  1  one-cycle pulse, writeback bundle valid
- wb_data  out  32  value for the register file
- rd_out  out  5  destination register
- rf_wb_out  out  1  register-file write enable, already qualified
- mem_exc  out  1  one-cycle pulse with out_valid: misaligned or illegal access

## Operation
- Classification from the accepted control word:
  - load: wb_src == 2'b01 and mem_we == 0
  - store: mem_we == 1
  - otherwise a non-memory op
- Legal funct3 for loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal funct3 for stores: 000 SB, 001 SH, 010 SW. Any other value is illegal.
- Misaligned: a halfword access with addr[0] = 1, or a word access with addr[1:0] != 0.
- State machine:
  - IDLE: in_ready = 1. On in_valid, latch all inputs.
    - Legal, aligned memory op: go to ACCESS.
    - Non-memory, misaligned or illegal op: load the output registers directly and stay in IDLE.
  - ACCESS: in_ready = 0, dmem_req = 1, and dmem_we/addr/wstrb/wdata are driven from latched registers, stable until ready. On dmem_ready: load the output registers and go to IDLE.
- Store lanes, with a = addr[1:0]:
  - SB: wstrb = 4'b0001 << a, wdata = {4{rs2[7:0]}}
  - SH: wstrb = 4'b0011 << a, wdata = {2{rs2[15:0]}}
  - SW: wstrb = 4'b1111, wdata = rs2
- Load extraction: select the byte or halfword from dmem_rdata by a. LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- Writeback:
  - wb_data = extracted load data for loads; ALU_result for all other ops, including stores.
  - rf_wb_out = rf_wb & ~exception.
  - rd_out = latched rd.
- Exception ops (misaligned or illegal): no bus access is made. mem_exc = 1 and rf_wb_out = 0. out_valid still pulses.
- branch_taken_ex and pc_src are not consumed by this stage; the fetch path handles redirects.

## Timing
- Reset (asynchronous, immediate): state = IDLE. in_ready = 1 after release. All other outputs are 0: dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata, out_valid, wb_data, rd_out, rf_wb_out, mem_exc.
- Reset during ACCESS drops dmem_req in the same cycle and discards the latched op.
- Non-memory or exception op accepted at edge N: out_valid is high in cycle N+1 only. A new bundle can be accepted at N+1, so throughput is one bundle per cycle.
- Memory op accepted at edge N: dmem_req is high from cycle N+1. If dmem_ready is first seen at edge N+k (k ≥ 1), out_valid pulses in cycle N+k+1, and in_ready returns to 1 in that same cycle. Minimum latency is 2 cycles.
- dmem_ready while dmem_req = 0 is ignored. Exactly one request is outstanding at a time.
- out_valid has no backpressure; writeback always consumes it.

## Test plan
- Reset: hold rst_n low mid-ACCESS with dmem_ready = 0 → dmem_req falls immediately; after release, in_ready = 1 and all other outputs are 0.
- Non-memory op: rd = 5, rf_wb = 1, ALU_result = 0x1234_5678 → out_valid next cycle with wb_data = 0x1234_5678, rd_out = 5, no dmem_req. Back-to-back ops produce one result per cycle.
- LB at 0x1003 with dmem_rdata = 0x80AA_BBCC and dmem_ready after 3 wait cycles → dmem_addr = 0x1000, wstrb = 0. out_valid arrives 5 cycles after accept with wb_data = 0xFFFF_FF80. The same access as LBU gives 0x0000_0080.
- SH at 0x2002 with rs2 = 0xDEAD_BEEF → wstrb = 4'b1100, wdata = 0xBEEF_BEEF, dmem_we = 1. out_valid arrives with rf_wb_out = 0 and wb_data = ALU_result.
- LW at 0x3001 → no dmem_req, out_valid and mem_exc pulse next cycle, rf_wb_out = 0. funct3 = 011 on a store gives the same response.
- LHU at 0x4002 with dmem_rdata = 0xF00D_1234 and immediate dmem_ready → wb_data = 0x0000_F00D. in_ready is low for exactly 1 cycle.

Source files
------------

// File: rtl/memory_stage.sv
// Memory-access stage: byte/halfword/word loads and stores over a
// single-outstanding req/ready port, producing a registered writeback bundle.
module memory_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [13:0] control_word_ex,
    input  logic [31:0] ALU_result,
    input  logic [31:0] calculated_adr,
    input  logic [31:0] regfileb_ex,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        out_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  rd_out,
    output logic        rf_wb_out,
    output logic        mem_exc
);

    localparam int unsigned XLEN = 32;

    typedef enum logic {S_IDLE, S_ACCESS} state_t;

    state_t            state_q;
    logic              we_q, is_load_q, rf_wb_q;
    logic [XLEN-1:0]   addr_q, wdata_q, alu_q;
    logic [3:0]        wstrb_q;
    logic [2:0]        funct3_q;
    logic [4:0]        rd_q;
    logic              out_valid_q, rf_wb_out_q, mem_exc_q;
    logic [XLEN-1:0]   wb_data_q;
    logic [4:0]        rd_out_q;

    // Control word fields
    logic       rf_wb_c, mem_we_c;
    logic [1:0] wb_src_c;
    logic [4:0] rd_c;
    logic [2:0] funct3_c;
    logic [1:0] lane_c;
    logic       unused_ctrl_c;

    assign rf_wb_c       = control_word_ex[12];
    assign mem_we_c      = control_word_ex[11];
    assign wb_src_c      = control_word_ex[10:9];
    assign rd_c          = control_word_ex[7:3];
    assign funct3_c      = control_word_ex[2:0];
    assign lane_c        = calculated_adr[1:0];
    assign unused_ctrl_c = control_word_ex[13] ^ control_word_ex[8];

    logic            is_load_c, is_store_c, is_mem_c, illegal_c, misaligned_c, exc_c;
    logic [3:0]      wstrb_c;
    logic [XLEN-1:0] wdata_c;

    // Classify the incoming op and form store lanes
    always_comb begin
        is_store_c   = mem_we_c;
        is_load_c    = (wb_src_c == 2'b01) && !mem_we_c;
        is_mem_c     = is_load_c || is_store_c;
        illegal_c    = 1'b0;
        misaligned_c = 1'b0;
        wstrb_c      = 4'b0000;
        wdata_c      = regfileb_ex;
        if (is_store_c) begin
            illegal_c = !(funct3_c == 3'b000 || funct3_c == 3'b001 || funct3_c == 3'b010);
        end else if (is_load_c) begin
            illegal_c = !(funct3_c == 3'b000 || funct3_c == 3'b001 || funct3_c == 3'b010 ||
                          funct3_c == 3'b100 || funct3_c == 3'b101);
        end
        case (funct3_c[1:0])
            2'b01:   misaligned_c = lane_c[0];
            2'b10:   misaligned_c = (lane_c != 2'b00);
            default: misaligned_c = 1'b0;
        endcase
        case (funct3_c[1:0])
            2'b00: begin
                wstrb_c = 4'b0001 << lane_c;
                wdata_c = {4{regfileb_ex[7:0]}};
            end
            2'b01: begin
                wstrb_c = 4'b0011 << lane_c;
                wdata_c = {2{regfileb_ex[15:0]}};
            end
            default: begin
                wstrb_c = 4'b1111;
                wdata_c = regfileb_ex;
            end
        endcase
        if (!is_store_c) wstrb_c = 4'b0000;
        exc_c = is_mem_c && (illegal_c || misaligned_c);
    end

    logic [7:0]      byte_c;
    logic [15:0]     half_c;
    logic [XLEN-1:0] load_data_c;

    // Extract and extend load data from the returned word
    always_comb begin
        byte_c = 8'(dmem_rdata >> {addr_q[1:0], 3'b000});
        half_c = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_data_c = {{24{byte_c[7]}}, byte_c};
            3'b001:  load_data_c = {{16{half_c[15]}}, half_c};
            3'b100:  load_data_c = {24'd0, byte_c};
            3'b101:  load_data_c = {16'd0, half_c};
            default: load_data_c = dmem_rdata;
        endcase
    end

    // Stage FSM with latched access and registered writeback bundle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            is_load_q   <= 1'b0;
            rf_wb_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            alu_q       <= '0;
            wstrb_q     <= 4'b0000;
            funct3_q    <= 3'b000;
            rd_q        <= 5'd0;
            out_valid_q <= 1'b0;
            rf_wb_out_q <= 1'b0;
            mem_exc_q   <= 1'b0;
            wb_data_q   <= '0;
            rd_out_q    <= 5'd0;
        end else begin
            out_valid_q <= 1'b0;
            mem_exc_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        if (is_mem_c && !exc_c) begin
                            state_q   <= S_ACCESS;
                            we_q      <= is_store_c;
                            is_load_q <= is_load_c;
                            rf_wb_q   <= rf_wb_c;
                            addr_q    <= calculated_adr;
                            wdata_q   <= wdata_c;
                            wstrb_q   <= wstrb_c;
                            alu_q     <= ALU_result;
                            funct3_q  <= funct3_c;
                            rd_q      <= rd_c;
                        end else begin
                            out_valid_q <= 1'b1;
                            mem_exc_q   <= exc_c;
                            wb_data_q   <= ALU_result;
                            rd_out_q    <= rd_c;
                            rf_wb_out_q <= rf_wb_c && !exc_c;
                        end
                    end
                end
                S_ACCESS: begin
                    if (dmem_ready) begin
                        state_q     <= S_IDLE;
                        out_valid_q <= 1'b1;
                        wb_data_q   <= is_load_q ? load_data_c : alu_q;
                        rd_out_q    <= rd_q;
                        rf_wb_out_q <= rf_wb_q;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign dmem_req   = (state_q == S_ACCESS);
    assign dmem_we    = we_q;
    assign dmem_addr  = {addr_q[31:2], 2'b00};
    assign dmem_wstrb = wstrb_q;
    assign dmem_wdata = wdata_q;
    assign out_valid  = out_valid_q;
    assign wb_data    = wb_data_q;
    assign rd_out     = rd_out_q;
    assign rf_wb_out  = rf_wb_out_q;
    assign mem_exc    = mem_exc_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed vector bench for memory_stage.
module tb_memory_stage;

    logic        clk, rst_n, in_valid, in_ready;
    logic [13:0] control_word_ex;
    logic [31:0] ALU_result, calculated_adr, regfileb_ex;
    logic        dmem_req, dmem_we, dmem_ready;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wstrb;
    logic        out_valid, rf_wb_out, mem_exc;
    logic [31:0] wb_data;
    logic [4:0]  rd_out;

    memory_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .control_word_ex(control_word_ex), .ALU_result(ALU_result),
        .calculated_adr(calculated_adr), .regfileb_ex(regfileb_ex),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
        .out_valid(out_valid), .wb_data(wb_data), .rd_out(rd_out),
        .rf_wb_out(rf_wb_out), .mem_exc(mem_exc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [13:0] cw;
        logic [31:0] alu, addr, rs2, rdata;
        int          delay;
        logic        mem, we;
        logic [31:0] maddr;
        logic [3:0]  wstrb;
        logic [31:0] wdata, wb;
        logic [4:0]  rd;
        logic        rfwb, exc;
        int          lat;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    function automatic logic [13:0] cw(input logic rf_wb, input logic mem_we,
                                       input logic [1:0] wb_src, input logic [4:0] rd,
                                       input logic [2:0] f3);
        return {1'b0, rf_wb, mem_we, wb_src, 1'b0, rd, f3};
    endfunction

    function automatic vec_t mk(input logic [13:0] c, input logic [31:0] alu, input logic [31:0] addr,
                                input logic [31:0] rs2, input logic [31:0] rdata, input int delay,
                                input logic mem, input logic we, input logic [31:0] maddr,
                                input logic [3:0] wstrb, input logic [31:0] wdata, input logic [31:0] wb,
                                input logic [4:0] rd, input logic rfwb, input logic exc, input int lat);
        vec_t v;
        v.cw = c; v.alu = alu; v.addr = addr; v.rs2 = rs2; v.rdata = rdata; v.delay = delay;
        v.mem = mem; v.we = we; v.maddr = maddr; v.wstrb = wstrb; v.wdata = wdata; v.wb = wb;
        v.rd = rd; v.rfwb = rfwb; v.exc = exc; v.lat = lat;
        return v;
    endfunction

    task automatic chk(input int idx, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL v%0d %s: got %h expected %h", idx, name, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input int idx);
        chk(idx, "in_ready", 32'(in_ready), 32'd1);
        chk(idx, "dmem_req", 32'(dmem_req), 32'd0);
        chk(idx, "dmem_we", 32'(dmem_we), 32'd0);
        chk(idx, "dmem_addr", dmem_addr, 32'd0);
        chk(idx, "dmem_wstrb", 32'(dmem_wstrb), 32'd0);
        chk(idx, "dmem_wdata", dmem_wdata, 32'd0);
        chk(idx, "out_valid", 32'(out_valid), 32'd0);
        chk(idx, "wb_data", wb_data, 32'd0);
        chk(idx, "rd_out", 32'(rd_out), 32'd0);
        chk(idx, "rf_wb_out", 32'(rf_wb_out), 32'd0);
        chk(idx, "mem_exc", 32'(mem_exc), 32'd0);
    endtask

    // Entered and left 1 time unit after a rising edge with the stage idle
    task automatic run_vec(input int idx, input vec_t v);
        int lat, waited, busy;
        in_valid        = 1'b1;
        control_word_ex = v.cw;
        ALU_result      = v.alu;
        calculated_adr  = v.addr;
        regfileb_ex     = v.rs2;
        dmem_rdata      = v.rdata;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1; waited = 0; busy = 0;
        chk(idx, "req", 32'(dmem_req), 32'(v.mem));
        if (v.mem) begin
            chk(idx, "addr", dmem_addr, v.maddr);
            chk(idx, "we", 32'(dmem_we), 32'(v.we));
            chk(idx, "wstrb", 32'(dmem_wstrb), 32'(v.wstrb));
            if (v.we) chk(idx, "wdata", dmem_wdata, v.wdata);
        end
        while (!out_valid && lat < 20) begin
            if (!in_ready) busy++;
            dmem_ready = dmem_req && (waited >= v.delay);
            if (dmem_req) waited++;
            @(posedge clk); #1;
            dmem_ready = 1'b0;
            lat++;
        end
        chk(idx, "out_valid", 32'(out_valid), 32'd1);
        chk(idx, "latency", 32'(lat), 32'(v.lat));
        chk(idx, "busy", 32'(busy), 32'(v.mem ? v.lat - 1 : 0));
        chk(idx, "in_ready", 32'(in_ready), 32'd1);
        chk(idx, "wb_data", wb_data, v.wb);
        chk(idx, "rd_out", 32'(rd_out), 32'(v.rd));
        chk(idx, "rf_wb_out", 32'(rf_wb_out), 32'(v.rfwb));
        chk(idx, "mem_exc", 32'(mem_exc), 32'(v.exc));
        chk(idx, "req_after", 32'(dmem_req), 32'd0);
    endtask

    initial begin
        vecs[0]  = mk(cw(1,0,2'b00,5'd5,3'b000), 32'h1234_5678, 32'h0, 32'h0, 32'h0, 0,
                      0,0, 32'h0, 4'h0, 32'h0, 32'h1234_5678, 5'd5, 1,0, 1);
        vecs[1]  = mk(cw(1,0,2'b01,5'd7,3'b000), 32'h0000_1003, 32'h1003, 32'h0, 32'h80AA_BBCC, 3,
                      1,0, 32'h1000, 4'h0, 32'h0, 32'hFFFF_FF80, 5'd7, 1,0, 5);
        vecs[2]  = mk(cw(1,0,2'b01,5'd7,3'b100), 32'h0000_1003, 32'h1003, 32'h0, 32'h80AA_BBCC, 3,
                      1,0, 32'h1000, 4'h0, 32'h0, 32'h0000_0080, 5'd7, 1,0, 5);
        vecs[3]  = mk(cw(0,1,2'b00,5'd0,3'b001), 32'h0000_2002, 32'h2002, 32'hDEAD_BEEF, 32'h0, 1,
                      1,1, 32'h2000, 4'b1100, 32'hBEEF_BEEF, 32'h0000_2002, 5'd0, 0,0, 3);
        vecs[4]  = mk(cw(1,0,2'b01,5'd9,3'b010), 32'h0000_3001, 32'h3001, 32'h0, 32'h0, 0,
                      0,0, 32'h0, 4'h0, 32'h0, 32'h0000_3001, 5'd9, 0,1, 1);
        vecs[5]  = mk(cw(0,1,2'b00,5'd0,3'b011), 32'h0000_3000, 32'h3000, 32'h1, 32'h0, 0,
                      0,0, 32'h0, 4'h0, 32'h0, 32'h0000_3000, 5'd0, 0,1, 1);
        vecs[6]  = mk(cw(1,0,2'b01,5'd10,3'b101), 32'h0000_4002, 32'h4002, 32'h0, 32'hF00D_1234, 0,
                      1,0, 32'h4000, 4'h0, 32'h0, 32'h0000_F00D, 5'd10, 1,0, 2);
        vecs[7]  = mk(cw(0,1,2'b00,5'd0,3'b000), 32'h0000_5001, 32'h5001, 32'h1234_5678, 32'h0, 0,
                      1,1, 32'h5000, 4'b0010, 32'h7878_7878, 32'h0000_5001, 5'd0, 0,0, 2);
        vecs[8]  = mk(cw(0,1,2'b00,5'd0,3'b010), 32'h0000_6000, 32'h6000, 32'hCAFE_BABE, 32'h0, 2,
                      1,1, 32'h6000, 4'b1111, 32'hCAFE_BABE, 32'h0000_6000, 5'd0, 0,0, 4);
        vecs[9]  = mk(cw(1,0,2'b01,5'd11,3'b001), 32'h0000_7002, 32'h7002, 32'h0, 32'h8001_0000, 2,
                      1,0, 32'h7000, 4'h0, 32'h0, 32'hFFFF_8001, 5'd11, 1,0, 4);
        vecs[10] = mk(cw(1,0,2'b01,5'd12,3'b001), 32'h0000_7001, 32'h7001, 32'h0, 32'h0, 0,
                      0,0, 32'h0, 4'h0, 32'h0, 32'h0000_7001, 5'd12, 0,1, 1);
        vecs[11] = mk(cw(0,0,2'b00,5'd3,3'b000), 32'h0000_0055, 32'h0, 32'h0, 32'h0, 0,
                      0,0, 32'h0, 4'h0, 32'h0, 32'h0000_0055, 5'd3, 0,0, 1);
        vecs[12] = mk(cw(1,0,2'b01,5'd4,3'b110), 32'h0000_0100, 32'h0100, 32'h0, 32'h0, 0,
                      0,0, 32'h0, 4'h0, 32'h0, 32'h0000_0100, 5'd4, 0,1, 1);
        vecs[13] = mk(cw(1,0,2'b01,5'd13,3'b010), 32'h0000_8004, 32'h8004, 32'h0, 32'h0BAD_F00D, 1,
                      1,0, 32'h8004, 4'h0, 32'h0, 32'h0BAD_F00D, 5'd13, 1,0, 3);

        rst_n = 1'b0; in_valid = 1'b0; control_word_ex = '0; ALU_result = '0;
        calculated_adr = '0; regfileb_ex = '0; dmem_ready = 1'b0; dmem_rdata = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk_idle_outputs(100);

        for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

        // Back-to-back non-memory ops: one result per cycle
        in_valid = 1'b1; control_word_ex = cw(1,0,2'b00,5'd1,3'b000); ALU_result = 32'hAAAA_0001;
        @(posedge clk); #1;
        chk(200, "b2b_ready", 32'(in_ready), 32'd1);
        chk(200, "b2b_valid1", 32'(out_valid), 32'd1);
        chk(200, "b2b_wb1", wb_data, 32'hAAAA_0001);
        control_word_ex = cw(1,0,2'b10,5'd2,3'b000); ALU_result = 32'hBBBB_0002;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk(200, "b2b_valid2", 32'(out_valid), 32'd1);
        chk(200, "b2b_wb2", wb_data, 32'hBBBB_0002);
        chk(200, "b2b_rd2", 32'(rd_out), 32'd2);
        @(posedge clk); #1;
        chk(200, "b2b_valid_drop", 32'(out_valid), 32'd0);

        // Reset while an access is outstanding
        in_valid = 1'b1; control_word_ex = cw(1,0,2'b01,5'd8,3'b010);
        calculated_adr = 32'h5000; ALU_result = 32'h5000;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk(300, "pre_rst_req", 32'(dmem_req), 32'd1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk(300, "rst_req_drop", 32'(dmem_req), 32'd0);
        chk(300, "rst_addr", dmem_addr, 32'd0);
        chk(300, "rst_rd_out", 32'(rd_out), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk_idle_outputs(301);
        dmem_ready = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        dmem_ready = 1'b0;
        repeat (2) begin
            chk(302, "rst_no_valid", 32'(out_valid), 32'd0);
            chk(302, "rst_no_req", 32'(dmem_req), 32'd0);
            @(posedge clk); #1;
        end
        chk(302, "rst_in_ready", 32'(in_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
